nco_hop_sequencer: RTL and testbench

//  Frequency-hop scheduler for the sin/cos frequency multiplier (LUT NCO).

---
 rtl/nco_hop_sequencer_pkg.sv | 36 +++
 rtl/nco_hop_sequencer_table.sv | 40 ++++
 rtl/nco_hop_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_nco_hop_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/nco_hop_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nco_hop_sequencer_pkg
//  Description : Shared types, constants and the frequency-select step map
//                for the NCO hop sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package nco_hop_sequencer_pkg;

    localparam int PHASE_W = 10;   // shadow phase width, mirrors NCO counter
    localparam int SEL_W   = 3;    // NCO frequency_select width

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRIME      = 3'd1,
        ST_RUN        = 3'd2,
        ST_WAIT_ALIGN = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    // Phase increment the NCO applies per cycle for a given frequency_select.
    function automatic logic [PHASE_W-1:0] step(input logic [SEL_W-1:0] sel);
        logic [PHASE_W-1:0] s;
        case (sel)
            3'd1:    s = 10'd1;
            3'd2:    s = 10'd2;
            3'd3:    s = 10'd4;
            3'd4:    s = 10'd8;
            3'd5:    s = 10'd16;
            default: s = 10'd0;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nco_hop_sequencer_table.sv
`default_nettype none
// ============================================================================
//  Module      : nco_hop_sequencer_table
//  Description : DEPTH-entry hop table (frequency_select + dwell), one
//                synchronous write port and one asynchronous read port.
//                Contents have no reset so they survive a sequencer reset.
//  Revision    : 1.0  initial release
// ============================================================================
module nco_hop_sequencer_table
    import nco_hop_sequencer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 16
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [SEL_W-1:0]           wsel,
    input  logic [DWELL_W-1:0]         wdwell,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [SEL_W-1:0]           rsel,
    output logic [DWELL_W-1:0]         rdwell
);

    logic [SEL_W-1:0]   sel_mem_q   [DEPTH];
    logic [DWELL_W-1:0] dwell_mem_q [DEPTH];

    // Table write; no reset so programmed entries persist.
    always_ff @(posedge clk) begin
        if (we) begin
            sel_mem_q[waddr]   <= wsel;
            dwell_mem_q[waddr] <= wdwell;
        end
    end

    assign rsel   = sel_mem_q[raddr];
    assign rdwell = dwell_mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/nco_hop_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : nco_hop_sequencer
//  Description : Plays a programmable (frequency_select, dwell) hop table
//                into a LUT NCO, with optional looping and optional hop
//                alignment to NCO phase zero via a shadow phase counter.
//  Revision    : 1.0  initial release
// ============================================================================
module nco_hop_sequencer
    import nco_hop_sequencer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 16,
    parameter int ALIGN   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       prog_we,
    input  logic [$clog2(DEPTH)-1:0]   prog_addr,
    input  logic [SEL_W-1:0]           prog_sel,
    input  logic [DWELL_W-1:0]         prog_dwell,
    input  logic [$clog2(DEPTH):0]     num_entries,
    input  logic                       loop_en,
    input  logic                       start,
    input  logic                       abort,
    output logic                       nco_reset,
    output logic [SEL_W-1:0]           frequency_select,
    output logic [$clog2(DEPTH)-1:0]   hop_index,
    output logic                       busy,
    output logic                       done
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    C_ONE   = (AW+1)'(1);
    localparam logic [AW:0]    C_DEPTH = (AW+1)'(DEPTH);

    state_t               state_q, state_d;
    logic [AW-1:0]        hop_index_q, hop_index_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [PHASE_W-1:0]   shadow_q, shadow_d;
    logic [SEL_W-1:0]     frequency_select_q, frequency_select_d;
    logic                 nco_reset_q, nco_reset_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [AW:0]          num_q, num_d;
    logic                 loop_q, loop_d;

    logic [AW-1:0]        next_index;
    logic                 is_last;
    logic [AW-1:0]        rd_addr;
    logic [SEL_W-1:0]     rd_sel;
    logic [DWELL_W-1:0]   rd_dwell;
    logic [DWELL_W-1:0]   dwell_load;
    logic [PHASE_W-1:0]   step_cur;
    logic                 align_ok;
    logic                 do_hop;

    // Table is locked while a sequence is playing.
    nco_hop_sequencer_table #(
        .DEPTH   (DEPTH),
        .DWELL_W (DWELL_W)
    ) u_table (
        .clk    (clk),
        .we     (prog_we && !busy_q),
        .waddr  (prog_addr),
        .wsel   (prog_sel),
        .wdwell (prog_dwell),
        .raddr  (rd_addr),
        .rsel   (rd_sel),
        .rdwell (rd_dwell)
    );

    // The read port always looks at the entry that would be loaded next:
    // entry 0 while priming, otherwise the successor of the current entry.
    assign is_last    = (({1'b0, hop_index_q} + C_ONE) == num_q);
    assign next_index = is_last ? '0 : hop_index_q + AW'(1);
    assign rd_addr    = (state_q == ST_PRIME) ? '0 : next_index;
    assign dwell_load = (rd_dwell == '0) ? DWELL_W'(1) : rd_dwell;

    // Next-state, dwell, shadow phase and registered-output computation.
    always_comb begin
        state_d            = state_q;
        hop_index_d        = hop_index_q;
        dwell_d            = dwell_q;
        frequency_select_d = frequency_select_q;
        nco_reset_d        = 1'b0;
        done_d             = 1'b0;
        num_d              = num_q;
        loop_d             = loop_q;
        do_hop             = 1'b0;
        step_cur           = step(frequency_select_q);
        shadow_d           = nco_reset_q ? '0 : shadow_q + step_cur;
        // A held NCO (step 0) never reaches phase 0 again, so hop anyway.
        align_ok           = (shadow_d == '0) || (step_cur == '0);

        case (state_q)
            ST_IDLE: begin
                frequency_select_d = '0;
                if (start && (num_entries != '0) && (num_entries <= C_DEPTH)) begin
                    state_d     = ST_PRIME;
                    nco_reset_d = 1'b1;
                    num_d       = num_entries;
                    loop_d      = loop_en;
                end
            end
            ST_PRIME: begin
                state_d            = ST_RUN;
                hop_index_d        = '0;
                dwell_d            = dwell_load;
                frequency_select_d = rd_sel;
            end
            ST_RUN: begin
                if (dwell_q > DWELL_W'(1)) begin
                    dwell_d = dwell_q - DWELL_W'(1);
                end else if (is_last && !loop_q) begin
                    state_d            = ST_DONE;
                    frequency_select_d = '0;
                    done_d             = 1'b1;
                end else if ((ALIGN == 0) || align_ok) begin
                    do_hop = 1'b1;
                end else begin
                    state_d = ST_WAIT_ALIGN;
                end
            end
            ST_WAIT_ALIGN: begin
                if (align_ok) begin
                    do_hop = 1'b1;
                end
            end
            ST_DONE: begin
                state_d            = ST_IDLE;
                frequency_select_d = '0;
            end
            default: begin
                state_d            = ST_IDLE;
                frequency_select_d = '0;
            end
        endcase

        if (do_hop) begin
            state_d            = ST_RUN;
            hop_index_d        = next_index;
            dwell_d            = dwell_load;
            frequency_select_d = rd_sel;
        end

        if (abort) begin
            state_d            = ST_IDLE;
            frequency_select_d = '0;
            nco_reset_d        = 1'b0;
            done_d             = 1'b0;
        end

        busy_d = (state_d == ST_PRIME) || (state_d == ST_RUN) ||
                 (state_d == ST_WAIT_ALIGN);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= ST_IDLE;
            hop_index_q        <= '0;
            dwell_q            <= '0;
            shadow_q           <= '0;
            frequency_select_q <= '0;
            nco_reset_q        <= 1'b0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            num_q              <= '0;
            loop_q             <= 1'b0;
        end else begin
            state_q            <= state_d;
            hop_index_q        <= hop_index_d;
            dwell_q            <= dwell_d;
            shadow_q           <= shadow_d;
            frequency_select_q <= frequency_select_d;
            nco_reset_q        <= nco_reset_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
            num_q              <= num_d;
            loop_q             <= loop_d;
        end
    end

    assign nco_reset        = nco_reset_q;
    assign frequency_select = frequency_select_q;
    assign hop_index        = hop_index_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule
`default_nettype wire

// File: tb/tb_nco_hop_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nco_hop_sequencer
//  Description : Directed self-checking bench for nco_hop_sequencer; one
//                instance with free hopping and one with phase-aligned hops.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nco_hop_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_we;
    logic [2:0]  prog_addr;
    logic [2:0]  prog_sel;
    logic [15:0] prog_dwell;
    logic [3:0]  num_entries;
    logic        loop_en;
    logic        start_a, start_b;
    logic        abort_a, abort_b;

    logic        nco_reset_a, busy_a, done_a;
    logic [2:0]  sel_a, hop_a;
    logic        nco_reset_b, busy_b, done_b;
    logic [2:0]  sel_b, hop_b;

    int n_checks = 0;
    int n_fail   = 0;
    int seq1 [9] = '{1, 1, 1, 1, 3, 3, 5, 5, 5};
    int cnt;

    always #5 clk = ~clk;

    nco_hop_sequencer #(.DEPTH(8), .DWELL_W(16), .ALIGN(0)) dut_a (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_sel(prog_sel), .prog_dwell(prog_dwell), .num_entries(num_entries),
        .loop_en(loop_en), .start(start_a), .abort(abort_a),
        .nco_reset(nco_reset_a), .frequency_select(sel_a), .hop_index(hop_a),
        .busy(busy_a), .done(done_a)
    );

    nco_hop_sequencer #(.DEPTH(8), .DWELL_W(16), .ALIGN(1)) dut_b (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_sel(prog_sel), .prog_dwell(prog_dwell), .num_entries(num_entries),
        .loop_en(loop_en), .start(start_b), .abort(abort_b),
        .nco_reset(nco_reset_b), .frequency_select(sel_b), .hop_index(hop_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic prog(input int addr, input int sel, input int dwell);
        prog_we    = 1'b1;
        prog_addr  = 3'(addr);
        prog_sel   = 3'(sel);
        prog_dwell = 16'(dwell);
        tick();
        prog_we    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_sel = '0; prog_dwell = '0;
        num_entries = '0; loop_en = 1'b0;
        start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_nco_reset", 32'(nco_reset_a), 0);
        check("rst_sel", 32'(sel_a), 0);
        check("rst_hop", 32'(hop_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);

        // Test 1: single pass of {(1,4),(3,2),(5,3)}
        prog(0, 1, 4); prog(1, 3, 2); prog(2, 5, 3);
        num_entries = 4'd3; loop_en = 1'b0; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("t1_prime_nco_reset", 32'(nco_reset_a), 1);
        check("t1_prime_busy", 32'(busy_a), 1);
        check("t1_prime_sel", 32'(sel_a), 0);
        tick();
        check("t1_run_nco_reset", 32'(nco_reset_a), 0);
        for (int k = 0; k < 9; k++) begin
            check("t1_sel", 32'(sel_a), 32'(seq1[k]));
            check("t1_busy", 32'(busy_a), 1);
            check("t1_done_low", 32'(done_a), 0);
            tick();
        end
        check("t1_done", 32'(done_a), 1);
        check("t1_done_sel", 32'(sel_a), 0);
        check("t1_done_busy", 32'(busy_a), 0);
        tick();
        check("t1_done_pulse_end", 32'(done_a), 0);

        // Test 2: looped table, then abort mid-entry
        loop_en = 1'b1; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        for (int k = 0; k < 15; k++) begin
            check("t2_loop_sel", 32'(sel_a), 32'(seq1[k % 9]));
            tick();
        end
        check("t2_mid_entry_sel", 32'(sel_a), 5);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("t2_abort_sel", 32'(sel_a), 0);
        check("t2_abort_busy", 32'(busy_a), 0);
        check("t2_abort_done", 32'(done_a), 0);
        tick();
        check("t2_abort_no_done", 32'(done_a), 0);
        check("t2_abort_idle_busy", 32'(busy_a), 0);

        // Test 4: zero dwell held one cycle; invalid num_entries ignored
        prog(0, 2, 0); prog(1, 4, 2);
        num_entries = 4'd2; loop_en = 1'b0; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        check("t4_dwell0_sel", 32'(sel_a), 2);
        tick();
        check("t4_entry1_sel_a", 32'(sel_a), 4);
        check("t4_entry1_hop", 32'(hop_a), 1);
        tick();
        check("t4_entry1_sel_b", 32'(sel_a), 4);
        tick();
        check("t4_done", 32'(done_a), 1);
        tick();
        num_entries = 4'd0; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("t4_num0_busy", 32'(busy_a), 0);
        check("t4_num0_nco_reset", 32'(nco_reset_a), 0);
        tick();
        check("t4_num0_busy_later", 32'(busy_a), 0);
        num_entries = 4'd9; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("t4_num9_busy", 32'(busy_a), 0);
        check("t4_num9_nco_reset", 32'(nco_reset_a), 0);

        // Test 5: writes and start while busy are ignored; reset mid-run
        prog(0, 1, 4); prog(1, 3, 2); prog(2, 5, 3);
        num_entries = 4'd3; loop_en = 1'b0; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        for (int k = 0; k < 9; k++) begin
            check("t5_sel", 32'(sel_a), 32'(seq1[k]));
            if (k == 0) begin
                prog_we = 1'b1; prog_addr = 3'd0; prog_sel = 3'd5; prog_dwell = 16'd1;
                start_a = 1'b1;
            end
            tick();
            prog_we = 1'b0; start_a = 1'b0;
        end
        check("t5_done", 32'(done_a), 1);
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("t5_rerun_sel", 32'(sel_a), 32'(seq1[k]));
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_sel", 32'(sel_a), 0);
        check("t5_rst_busy", 32'(busy_a), 0);
        check("t5_rst_hop", 32'(hop_a), 0);
        check("t5_rst_nco_reset", 32'(nco_reset_a), 0);
        check("t5_rst_done", 32'(done_a), 0);

        // Test 3: aligned hop waits for shadow phase wrap
        prog(0, 1, 3); prog(1, 2, 5);
        num_entries = 4'd2; loop_en = 1'b0; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("t3_prime_nco_reset", 32'(nco_reset_b), 1);
        tick();
        cnt = 0;
        while (sel_b == 3'd1 && cnt < 2000) begin
            cnt++;
            tick();
        end
        check("t3_entry0_cycles", 32'(cnt), 1024);
        check("t3_hop_sel", 32'(sel_b), 2);
        check("t3_hop_index", 32'(hop_b), 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3_entry1_sel", 32'(sel_b), 2);
        end
        tick();
        check("t3_done", 32'(done_b), 1);
        check("t3_done_sel", 32'(sel_b), 0);
        tick();

        // Test 6: sel=7 holds the NCO; aligned hop must not deadlock
        prog(0, 7, 2); prog(1, 1, 1);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        tick();
        check("t6_sel7_a", 32'(sel_b), 7);
        tick();
        check("t6_sel7_b", 32'(sel_b), 7);
        tick();
        check("t6_hop_sel", 32'(sel_b), 1);
        check("t6_hop_index", 32'(hop_b), 1);
        tick();
        check("t6_done", 32'(done_b), 1);
        check("t6_done_sel", 32'(sel_b), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
